regfile_scoreboard: RTL

Parametrised successor to the CPU register file. It provides N combinational read ports, two synchronous write ports with fixed priority, and optional write-to-read bypass. A per-register pending scoreboard lets the decode stage detect read-after-write hazards and stall. It sits between decode (reads, reserve) and write-back (writes, clear).

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_read_port.sv | 58 +++++
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with scoreboard.
// Holds the default configuration, the address/data types for that default
// configuration, and the register-zero guard used by the top and read ports.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 16;
    localparam int DEFAULT_NUM_READ   = 2;
    localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

    // True when register 0 is hardwired and the address selects it.
    // Callers widen their address to 32 bits so one function serves every
    // ADDR_WIDTH.
    function automatic logic zero_guard(input int zeroReg, input int unsigned addr);
        return (zeroReg != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Ports:
//   readAddr                 register selected by this port
//   regFile                  registered storage array
//   writeEnable0/1, writeAddr0/1, writeData0/1
//                            same-cycle writes, already qualified by reset
//                            and the register-zero rule (port 1 has priority)
//   pending                  registered scoreboard vector
//   readData                 operand value (bypassed when BYPASS != 0)
//   readPending              scoreboard bit of the addressed register
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0]                readAddr,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regFile,
    input  logic                                 writeEnable0,
    input  logic [ADDR_WIDTH-1:0]                writeAddr0,
    input  logic [DATA_WIDTH-1:0]                writeData0,
    input  logic                                 writeEnable1,
    input  logic [ADDR_WIDTH-1:0]                writeAddr1,
    input  logic [DATA_WIDTH-1:0]                writeData1,
    input  logic [NUM_REGS-1:0]                  pending,
    output logic [DATA_WIDTH-1:0]                readData,
    output logic                                 readPending
);

    always_comb begin
        // NOTE: both outputs get a default before any branch so every path
        // assigns them and no latch is inferred.
        readData    = regFile[readAddr];
        readPending = pending[readAddr];

        // A value being written this cycle is the freshest copy, so the
        // operand is ready even if the scoreboard still says pending.
        if (BYPASS != 0) begin
            if (writeEnable1 && (writeAddr1 == readAddr)) begin
                readData    = writeData1;
                readPending = 1'b0;
            end else if (writeEnable0 && (writeAddr0 == readAddr)) begin
                readData    = writeData0;
                readPending = 1'b0;
            end
        end

        // Register zero wins over everything, bypass included.
        if (zero_guard(ZERO_REG, 32'(readAddr))) begin
            readData    = '0;
            readPending = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with a per-register pending scoreboard.
// Decode reads operands and reserves destinations; write-back writes results
// and thereby clears the pending bit of the written register.
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   readAddr, readValid      packed read addresses / operand-used qualifiers
//   readData, readPending    packed read data / pending bit per read port
//   hazard                   some used operand is still pending
//   writeEnable0/1, writeAddr0/1, writeData0/1
//                            write ports; port 1 wins on an address clash
//   reserveEnable, reserveAddr
//                            mark a destination register as pending
//   pendingCount             number of pending registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int NUM_READ   = DEFAULT_NUM_READ,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddr,
    input  logic [NUM_READ-1:0]            readValid,
    output logic [NUM_READ*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ-1:0]            readPending,
    output logic                           hazard,
    input  logic                           writeEnable0,
    input  logic [ADDR_WIDTH-1:0]          writeAddr0,
    input  logic [DATA_WIDTH-1:0]          writeData0,
    input  logic                           writeEnable1,
    input  logic [ADDR_WIDTH-1:0]          writeAddr1,
    input  logic [DATA_WIDTH-1:0]          writeData1,
    input  logic                           reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          reserveAddr,
    output logic [ADDR_WIDTH:0]            pendingCount
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regFile;
    logic [NUM_REGS-1:0]                 pending;
    logic [NUM_REGS-1:0]                 pendingNext;
    logic                                writeActive0;
    logic                                writeActive1;
    logic                                reserveActive;

    // Qualified requests. Gating with rst_n keeps in-flight writes from being
    // forwarded to readData while reset is held.
    assign writeActive0  = rst_n && writeEnable0  && !zero_guard(ZERO_REG, 32'(writeAddr0));
    assign writeActive1  = rst_n && writeEnable1  && !zero_guard(ZERO_REG, 32'(writeAddr1));
    assign reserveActive = rst_n && reserveEnable && !zero_guard(ZERO_REG, 32'(reserveAddr));

    // Storage. Port 1 is assigned last so it wins when both ports target the
    // same register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the storage array is reset because every register must read
        // 0 after reset; this rules out a RAM macro for this block.
        if (!rst_n) begin
            regFile <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            if (writeActive0) regFile[writeAddr0] <= writeData0;
            if (writeActive1) regFile[writeAddr1] <= writeData1;
        end
    end

    // Scoreboard next state. A reserve beats a same-cycle write-back: the
    // newer producer owns the register.
    always_comb begin
        pendingNext = pending;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reserveActive && (reserveAddr == ADDR_WIDTH'(r))) begin
                pendingNext[r] = 1'b1;
            end else if ((writeActive0 && (writeAddr0 == ADDR_WIDTH'(r))) ||
                         (writeActive1 && (writeAddr1 == ADDR_WIDTH'(r)))) begin
                pendingNext[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // Popcount of the registered scoreboard.
    always_comb begin
        pendingCount = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pendingCount = pendingCount + (ADDR_WIDTH+1)'(pending[r]);
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        regfile_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_REGS   (NUM_REGS),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_readPort (
            .readAddr     (readAddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .regFile      (regFile),
            .writeEnable0 (writeActive0),
            .writeAddr0   (writeAddr0),
            .writeData0   (writeData0),
            .writeEnable1 (writeActive1),
            .writeAddr1   (writeAddr1),
            .writeData1   (writeData1),
            .pending      (pending),
            .readData     (readData[i*DATA_WIDTH +: DATA_WIDTH]),
            .readPending  (readPending[i])
        );
    end

    assign hazard = |(readValid & readPending);

endmodule
